matmul_ctrl_reg: RTL

MATMUL_CTRL_REG -- requirements
Module: matmul_ctrl_reg

---
 rtl/matmul_ctrl_reg.sv | 138 +++++++++++++
 1 files changed

// File: rtl/matmul_ctrl_reg.sv
// APB control/status register block for the matmul core: it latches the configuration,
// launches the core, and runs a watchdog over the RUN state.
module matmul_ctrl_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM_W      = 2,
  parameter int TIMEOUT    = 1024,
  localparam int CFG_W     = 10 + 3 * DIM_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [3:0]            paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [CFG_W-1:0]      cfg_o,
  output logic                  start_o,
  output logic                  busy_o,
  input  logic                  done_i,
  output logic                  abort_o,
  output logic                  irq_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             startPulse_q, startPulse_d;
  logic             abortPulse_q, abortPulse_d;
  logic             doneFlag_q, doneFlag_d;
  logic             errFlag_q, errFlag_d;
  logic             timeoutFlag_q, timeoutFlag_d;

  logic access, isCtrl, isStatus, ctrlWrite, statusWrite, readAccess, expire;
  logic doneSet, errSet, timeoutSet;
  logic unusedBits;

  assign unusedBits = ^{paddr_i[1:0], pwdata_i};

  assign pready_o    = 1'b1;
  assign access      = psel_i & penable_i & rst_ni;
  assign isCtrl      = (paddr_i[3:2] == 2'd0);
  assign isStatus    = (paddr_i[3:2] == 2'd1);
  assign ctrlWrite   = access & pwrite_i & isCtrl;
  assign statusWrite = access & pwrite_i & isStatus;
  assign readAccess  = access & ~pwrite_i;
  assign expire      = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  assign cfg_o   = cfg_q;
  assign start_o = startPulse_q;
  assign abort_o = abortPulse_q;
  assign busy_o  = (state_q == RUN);
  assign irq_o   = doneFlag_q | timeoutFlag_q;

  always_comb begin
    pslverr_o = access & ~(isCtrl | isStatus);
    if (ctrlWrite && state_q == RUN) pslverr_o = 1'b1;
    prdata_o = '0;
    if (readAccess && isCtrl) begin
      prdata_o = DATA_WIDTH'({cfg_q[CFG_W-1:1], busy_o});
    end else if (readAccess && isStatus) begin
      prdata_o = DATA_WIDTH'({timeoutFlag_q, errFlag_q, doneFlag_q, busy_o});
    end
  end

  // Done beats a same-cycle watchdog expiry; the counter only advances while no exit is taken.
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    cnt_d        = cnt_q;
    startPulse_d = 1'b0;
    abortPulse_d = 1'b0;
    doneSet      = 1'b0;
    errSet       = 1'b0;
    timeoutSet   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrlWrite) begin
          cfg_d = {pwdata_i[CFG_W-1:1], 1'b0};
          if (pwdata_i[0]) begin
            state_d      = RUN;
            startPulse_d = 1'b1;
            cnt_d        = '0;
          end
        end
      end
      RUN: begin
        if (ctrlWrite) errSet = 1'b1;
        if (done_i) begin
          state_d = IDLE;
          doneSet = 1'b1;
        end else if (TIMEOUT > 0) begin
          if (expire) begin
            state_d      = IDLE;
            abortPulse_d = 1'b1;
            timeoutSet   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    doneFlag_d    = doneSet    | (doneFlag_q    & ~(statusWrite & pwdata_i[1]));
    errFlag_d     = errSet     | (errFlag_q     & ~(statusWrite & pwdata_i[2]));
    timeoutFlag_d = timeoutSet | (timeoutFlag_q & ~(statusWrite & pwdata_i[3]));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cfg_q         <= '0;
      cnt_q         <= '0;
      startPulse_q  <= 1'b0;
      abortPulse_q  <= 1'b0;
      doneFlag_q    <= 1'b0;
      errFlag_q     <= 1'b0;
      timeoutFlag_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      cnt_q         <= cnt_d;
      startPulse_q  <= startPulse_d;
      abortPulse_q  <= abortPulse_d;
      doneFlag_q    <= doneFlag_d;
      errFlag_q     <= errFlag_d;
      timeoutFlag_q <= timeoutFlag_d;
    end
  end

endmodule
